// File: rtl/parking_lot_controller_if.sv
// Parking lot controller bus.
// Groups the sensor pulses, entry request and controller status into one bundle.
//   master : sensor/driver side; drives entry_req, enter and exit, and observes the status
//   slave  : controller side; consumes the requests and pulses, and drives the status
// Signals:
//   entry_req  level, the driver at the entry wants the gate
//   enter      one-cycle pulse, a car completed entry
//   exit       one-cycle pulse, a car completed exit
//   gate_open  entry gate open command
//   occupancy  cars currently inside
//   full       occupancy plus the reserved space equals capacity
//   empty      no cars inside and no reservation
//   timeout    one-cycle pulse, an open grant expired unused
//   error      one-cycle pulse, an unauthorised enter or an exit at zero
interface parking_lot_controller_if #(
  parameter int CNT_W = 5
) ();
  logic             entry_req;
  logic             enter;
  logic             exit;
  logic             gate_open;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             timeout;
  logic             error;

  modport master (
    output entry_req, enter, exit,
    input  gate_open, occupancy, full, empty, timeout, error
  );

  modport slave (
    input  entry_req, enter, exit,
    output gate_open, occupancy, full, empty, timeout, error
  );
endinterface

// File: rtl/parking_lot_controller.sv
// Parking lot occupancy manager and entry-gate sequencer.
// The controller keeps the car count from the sensor FSM's enter/exit pulses.
// It grants entry-gate openings only while a space is free.
// Each grant reserves one space until the car is sensed or the grant times out.
// All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    parking_lot_controller_if.slave
//          inputs  : entry_req, enter, exit
//          outputs : gate_open, occupancy, full, empty, timeout, error
module parking_lot_controller #(
  parameter int CAPACITY = 25,
  parameter int CNT_W    = 5,
  parameter int TIMEOUT  = 50,
  parameter int TO_W     = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  parking_lot_controller_if.slave  bus
);

  typedef enum logic [1:0] {G_IDLE, G_OPEN, G_HOLD} gstate_t;

  gstate_t          state, state_nxt;
  logic [CNT_W-1:0] occ, occ_nxt;
  logic             res, res_nxt;
  logic [TO_W-1:0]  timer, timer_nxt;
  logic             gate_q, gate_nxt;
  logic             timeout_q, timeout_nxt;
  logic             error_q, error_nxt;
  logic             full_q, full_nxt;
  logic             empty_q, empty_nxt;

  logic [CNT_W:0]   load;       // occupancy + reservation
  logic             avail;
  logic             in_open;
  logic             tailgate;
  logic             enter_ok;
  logic             exit_ok;
  logic             grant;
  logic             tim_last;

  assign load     = {1'b0, occ} + {{CNT_W{1'b0}}, res};
  assign avail    = load < (CNT_W+1)'(CAPACITY);
  assign in_open  = (state == G_OPEN);
  assign tim_last = (timer == TO_W'(TIMEOUT - 1));

  // An enter pulse while the gate is open consumes the reservation.
  // This is always accepted.
  // Any other enter pulse is a tailgate: it is counted only if a space is free.
  assign tailgate = bus.enter & ~in_open;
  assign enter_ok = bus.enter & (in_open | avail);

  // An exit is checked against the count after the enter pulse.
  // An exit at zero that coincides with an accepted enter therefore nets to zero.
  assign exit_ok  = bus.exit & ((occ != '0) | enter_ok);

  // A tailgate accepted on the same edge takes the space first.
  // The grant must not reserve that space as well.
  assign grant    = (state == G_IDLE) & bus.entry_req &
                    ((load + {{CNT_W{1'b0}}, tailgate}) < (CNT_W+1)'(CAPACITY));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= G_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      G_IDLE:  if (grant) state_nxt = G_OPEN;
      G_OPEN:  if (bus.enter || tim_last) state_nxt = G_HOLD;
      G_HOLD:  state_nxt = G_IDLE;
      default: state_nxt = G_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and of the counters
  always_comb begin
    res_nxt     = res;
    timer_nxt   = timer;
    gate_nxt    = gate_q;
    timeout_nxt = 1'b0;
    case (state)
      G_IDLE: begin
        if (grant) begin
          res_nxt   = 1'b1;
          timer_nxt = '0;
          gate_nxt  = 1'b1;
        end
      end
      G_OPEN: begin
        if (bus.enter) begin
          res_nxt  = 1'b0;
          gate_nxt = 1'b0;
        end else if (tim_last) begin
          res_nxt     = 1'b0;
          gate_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end else begin
          timer_nxt = timer + TO_W'(1);
        end
      end
      default: begin
        res_nxt  = 1'b0;
        gate_nxt = 1'b0;
      end
    endcase

    case ({enter_ok, exit_ok})
      2'b10:   occ_nxt = occ + CNT_W'(1);
      2'b01:   occ_nxt = occ - CNT_W'(1);
      default: occ_nxt = occ;
    endcase

    error_nxt = tailgate | (bus.exit & ~exit_ok);
    full_nxt  = ({1'b0, occ_nxt} + {{CNT_W{1'b0}}, res_nxt}) == (CNT_W+1)'(CAPACITY);
    empty_nxt = (occ_nxt == '0) & ~res_nxt;
  end

  // Registers for the counters and outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ       <= '0;
      res       <= 1'b0;
      timer     <= '0;
      gate_q    <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      occ       <= occ_nxt;
      res       <= res_nxt;
      timer     <= timer_nxt;
      gate_q    <= gate_nxt;
      timeout_q <= timeout_nxt;
      error_q   <= error_nxt;
      full_q    <= full_nxt;
      empty_q   <= empty_nxt;
    end
  end

  assign bus.gate_open = gate_q;
  assign bus.occupancy = occ;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.timeout   = timeout_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Directed testbench for parking_lot_controller.
// Inputs are driven 1 time unit after the rising edge.
// Outputs are sampled at the same point, so they reflect that edge.
module tb_parking_lot_controller;
  localparam int CAP = 25;
  localparam int CW  = 5;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_lot_controller_if #(.CNT_W(CW)) bus ();

  parking_lot_controller #(
    .CAPACITY(CAP), .CNT_W(CW), .TIMEOUT(TO), .TO_W(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request the gate, wait a bounded time for the grant, then drive the car in.
  // Ends with the FSM back in G_IDLE.
  task automatic grant_enter();
    int n;
    n = 0;
    bus.entry_req = 1'b1;
    while (!bus.gate_open && n < 10) begin
      tick();
      n++;
    end
    chk("grant", 32'(bus.gate_open), 1);
    bus.entry_req = 1'b0;
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    tick();
  endtask

  initial begin
    bit closed;
    reset         = 1'b1;
    bus.entry_req = 1'b0;
    bus.enter     = 1'b0;
    bus.exit      = 1'b0;
    tick();
    tick();
    chk("rst_gate",    32'(bus.gate_open), 0);
    chk("rst_occ",     32'(bus.occupancy), 0);
    chk("rst_full",    32'(bus.full),      0);
    chk("rst_empty",   32'(bus.empty),     1);
    chk("rst_timeout", 32'(bus.timeout),   0);
    chk("rst_error",   32'(bus.error),     0);
    reset = 1'b0;
    tick();

    // 1: grant latency and first entry
    bus.entry_req = 1'b1;
    tick();
    chk("t1_gate_up", 32'(bus.gate_open), 1);
    chk("t1_empty_res", 32'(bus.empty), 0);
    chk("t1_occ0", 32'(bus.occupancy), 0);
    bus.entry_req = 1'b0;
    tick();
    tick();
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    chk("t1_gate_dn", 32'(bus.gate_open), 0);
    chk("t1_occ1", 32'(bus.occupancy), 1);
    chk("t1_empty", 32'(bus.empty), 0);
    chk("t1_err", 32'(bus.error), 0);
    tick();

    // 2: fill to capacity, tailgate saturation, held request, freed space
    repeat (24) grant_enter();
    chk("t2_occ25", 32'(bus.occupancy), 25);
    chk("t2_full", 32'(bus.full), 1);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    chk("t2_tg_err", 32'(bus.error), 1);
    chk("t2_tg_sat", 32'(bus.occupancy), 25);
    tick();
    chk("t2_err_clr", 32'(bus.error), 0);
    bus.entry_req = 1'b1;
    closed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.gate_open !== 1'b0) closed = 1'b0;
    end
    chk("t2_held_closed", 32'(closed), 1);
    bus.exit = 1'b1;
    tick();
    bus.exit = 1'b0;
    chk("t2_exit_occ", 32'(bus.occupancy), 24);
    chk("t2_not_full", 32'(bus.full), 0);
    chk("t2_gate_wait", 32'(bus.gate_open), 0);
    tick();
    chk("t2_regrant", 32'(bus.gate_open), 1);
    chk("t2_full_res", 32'(bus.full), 1);
    bus.entry_req = 1'b0;

    // 3: grant expires unused
    repeat (TO - 1) tick();
    chk("t3_gate_still", 32'(bus.gate_open), 1);
    chk("t3_no_to_yet", 32'(bus.timeout), 0);
    tick();
    chk("t3_gate_dn", 32'(bus.gate_open), 0);
    chk("t3_to_pulse", 32'(bus.timeout), 1);
    chk("t3_occ", 32'(bus.occupancy), 24);
    chk("t3_res_clr", 32'(bus.full), 0);
    tick();
    chk("t3_to_once", 32'(bus.timeout), 0);

    // 6: asynchronous reset in the middle of a grant
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    repeat (20) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_gate", 32'(bus.gate_open), 0);
    chk("t6_occ", 32'(bus.occupancy), 0);
    chk("t6_empty", 32'(bus.empty), 1);
    chk("t6_full", 32'(bus.full), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("t6_idle", 32'(bus.gate_open), 0);

    // 4: errors at zero and tailgating
    bus.enter = 1'b1;
    bus.exit  = 1'b1;
    tick();
    bus.enter = 1'b0;
    bus.exit  = 1'b0;
    chk("t4_net0_occ", 32'(bus.occupancy), 0);
    chk("t4_net0_err", 32'(bus.error), 1);
    tick();
    chk("t4_err_clr0", 32'(bus.error), 0);
    bus.exit = 1'b1;
    tick();
    bus.exit = 1'b0;
    chk("t4_exit0_err", 32'(bus.error), 1);
    chk("t4_exit0_occ", 32'(bus.occupancy), 0);
    tick();
    chk("t4_err_clr1", 32'(bus.error), 0);
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    chk("t4_tg_err", 32'(bus.error), 1);
    chk("t4_tg_occ", 32'(bus.occupancy), 1);
    chk("t4_tg_empty", 32'(bus.empty), 0);
    tick();

    // 5: simultaneous enter and exit during G_OPEN
    repeat (4) grant_enter();
    chk("t5_occ5", 32'(bus.occupancy), 5);
    bus.entry_req = 1'b1;
    tick();
    bus.entry_req = 1'b0;
    chk("t5_gate", 32'(bus.gate_open), 1);
    tick();
    bus.enter = 1'b1;
    bus.exit  = 1'b1;
    tick();
    bus.enter = 1'b0;
    bus.exit  = 1'b0;
    chk("t5_occ", 32'(bus.occupancy), 5);
    chk("t5_err", 32'(bus.error), 0);
    chk("t5_gate_dn", 32'(bus.gate_open), 0);
    bus.entry_req = 1'b1;
    tick();
    chk("t5_hold_ignores", 32'(bus.gate_open), 0);
    tick();
    chk("t5_regrant", 32'(bus.gate_open), 1);
    bus.entry_req = 1'b0;
    bus.enter = 1'b1;
    tick();
    bus.enter = 1'b0;
    chk("t5_occ6", 32'(bus.occupancy), 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
